// File: rtl/debug_slave_pkg.sv
// Shared types for the debug-slave command path: IR codes and the queued
// command layout at the default register widths.
package debug_slave_pkg;

   localparam int DBG_DR_W = 38;
   localparam int DBG_IR_W = 2;

   typedef enum logic [DBG_IR_W-1:0] {
      OCIMEM    = 2'd0,
      TRACE     = 2'd1,
      BREAK     = 2'd2,
      TRACECTRL = 2'd3
   } ir_code_e;

   typedef struct packed {
      logic [DBG_IR_W-1:0] ir;
      logic [DBG_DR_W-1:0] data;
   } cmd_entry_t;

endpackage

// File: rtl/debug_slave_sync.sv
// Brings one asynchronous JTAG strobe into clk and turns each rising edge into a
// single-cycle event; edges are ignored just after reset so a stuck-high level is not seen.
module debug_slave_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_event
);

   localparam int MASK_W = $clog2(SYNC_STAGES + 2);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_evt;
   logic [MASK_W-1:0]      r_mask_cnt;
   logic                   w_masked;

   assign w_masked = (r_mask_cnt != '0);
   assign o_event  = r_evt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync     <= '0;
         r_prev     <= 1'b0;
         r_evt      <= 1'b0;
         r_mask_cnt <= MASK_W'(SYNC_STAGES + 1);
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
         // The mask covers exactly the window in which a pre-reset level reaches the detector.
         r_evt  <= r_sync[SYNC_STAGES-1] & ~r_prev & ~w_masked;
         if (w_masked)
            r_mask_cnt <= r_mask_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/debug_slave_cmd_sync.sv
// Debug-slave command synchroniser: IR/DR update strobes from the JTAG side are
// synchronised, captured as {ir, data} commands and queued in a show-ahead FIFO.
module debug_slave_cmd_sync
   import debug_slave_pkg::*;
#(
   parameter int DR_W        = DBG_DR_W,
   parameter int IR_W        = DBG_IR_W,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 vs_uir,
   input  logic                 vs_e1dr,
   input  logic [IR_W-1:0]      ir_in,
   input  logic [DR_W-1:0]      sr,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic [IR_W-1:0]      cmd_ir,
   output logic [DR_W-1:0]      jdo,
   output logic [2**IR_W-1:0]   take_action,
   input  logic                 ovf_clr,
   output logic                 overflow,
   output logic [7:0]           drop_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [IR_W-1:0] ir;
      logic [DR_W-1:0] data;
   } entry_t;

   logic w_uir_evt;
   logic w_e1dr_evt;

   debug_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
      .clk     (clk),
      .reset   (reset),
      .i_async (vs_uir),
      .o_event (w_uir_evt)
   );

   debug_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_e1dr (
      .clk     (clk),
      .reset   (reset),
      .i_async (vs_e1dr),
      .o_event (w_e1dr_evt)
   );

   logic [IR_W-1:0] r_ir;
   logic            r_push_vld;
   entry_t          r_push_entry;

   // Capture uses the IR value before a coincident IR update lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ir         <= '0;
         r_push_vld   <= 1'b0;
         r_push_entry <= '0;
      end else begin
         r_push_vld <= w_e1dr_evt;
         if (w_e1dr_evt)
            r_push_entry <= '{ir: r_ir, data: sr};
         if (w_uir_evt)
            r_ir <= ir_in;
      end
   end

   entry_t           r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;
   logic [7:0]       r_drop_count;
   logic             w_full;
   logic             w_pop;
   logic             w_wr;
   logic             w_drop;

   assign cmd_valid  = (r_count != '0);
   assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_pop      = cmd_valid & cmd_ready;
   assign w_wr       = r_push_vld & (~w_full | w_pop);
   assign w_drop     = r_push_vld & w_full & ~w_pop;
   assign cmd_ir     = r_mem[r_rd_ptr].ir;
   assign jdo        = r_mem[r_rd_ptr].data;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;

   always_comb begin
      take_action = '0;
      if (w_pop)
         take_action[cmd_ir] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= r_push_entry;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_wr)
            r_count <= r_count - 1'b1;

         // A drop wins over a coincident clear so the lost event stays visible.
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (ovf_clr)
               r_drop_count <= 8'd1;
            else if (r_drop_count != 8'hFF)
               r_drop_count <= r_drop_count + 8'd1;
         end else if (ovf_clr) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_debug_slave_cmd_sync.sv
// Randomised and directed bench for debug_slave_cmd_sync against a queue-level
// reference model of the command path.
module tb_debug_slave_cmd_sync;
   import debug_slave_pkg::*;

   localparam int SYNC  = 2;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vs_uir = 1'b0;
   logic        vs_e1dr = 1'b0;
   logic [1:0]  ir_in = '0;
   logic [37:0] sr = '0;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [1:0]  cmd_ir;
   logic [37:0] jdo;
   logic [3:0]  take_action;
   logic        ovf_clr = 1'b0;
   logic        overflow;
   logic [7:0]  drop_count;

   debug_slave_cmd_sync #(
      .DR_W(38), .IR_W(2), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_e1dr(vs_e1dr),
      .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .jdo(jdo), .take_action(take_action),
      .ovf_clr(ovf_clr), .overflow(overflow), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: a rising level seen on two consecutive post-reset samples becomes
   // an event; its command is captured SYNC+1 edges later and enters the queue one edge after that.
   cmd_entry_t m_q[$];
   int         e_due[$];
   int         u_due[$];
   int         m_cyc = 0;
   bit         prev_ok = 0;
   logic       e_prev = 0, u_prev = 0;
   bit         stg_vld = 0;
   cmd_entry_t stg;
   logic [1:0] m_ir = '0;
   bit         m_ovf = 0;
   int         m_drop = 0;

   always @(posedge clk) begin
      bit m_pop;
      bit m_dropped;
      if (reset) begin
         m_q.delete(); e_due.delete(); u_due.delete();
         prev_ok = 0; stg_vld = 0; m_ir = '0; m_ovf = 0; m_drop = 0;
      end else begin
         m_pop = (m_q.size() != 0) && cmd_ready;
         m_dropped = 0;
         if (m_pop)
            void'(m_q.pop_front());
         if (stg_vld) begin
            if (m_q.size() == DEPTH) m_dropped = 1;
            else m_q.push_back(stg);
         end
         if (m_dropped) begin
            m_ovf = 1;
            m_drop = ovf_clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
         end else if (ovf_clr) begin
            m_ovf = 0;
            m_drop = 0;
         end
         stg_vld = 0;
         if (e_due.size() != 0 && e_due[0] == m_cyc) begin
            void'(e_due.pop_front());
            stg_vld = 1;
            stg.ir = m_ir;
            stg.data = sr;
         end
         if (u_due.size() != 0 && u_due[0] == m_cyc) begin
            void'(u_due.pop_front());
            m_ir = ir_in;
         end
         if (prev_ok && !e_prev && vs_e1dr) e_due.push_back(m_cyc + SYNC + 1);
         if (prev_ok && !u_prev && vs_uir)  u_due.push_back(m_cyc + SYNC + 1);
         prev_ok = 1;
      end
      e_prev = vs_e1dr;
      u_prev = vs_uir;
      m_cyc++;
   end

   logic [37:0] log_d[$];
   logic [1:0]  log_ir[$];
   int          ta_pulses = 0;
   logic [3:0]  last_ta = '0;

   always @(negedge clk) begin
      bit         exp_valid;
      logic [3:0] exp_ta;
      exp_valid = (m_q.size() != 0);
      chk("cmd_valid", 64'(cmd_valid), 64'(exp_valid));
      exp_ta = 4'b0000;
      if (exp_valid) begin
         chk("cmd_ir", 64'(cmd_ir), 64'(m_q[0].ir));
         chk("jdo", 64'(jdo), 64'(m_q[0].data));
         if (cmd_ready) exp_ta[m_q[0].ir] = 1'b1;
      end
      chk("take_action", 64'(take_action), 64'(exp_ta));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      if (cmd_valid && cmd_ready) begin
         log_d.push_back(jdo);
         log_ir.push_back(cmd_ir);
         $display("pop ir=%0d jdo=%0h take=%b", cmd_ir, jdo, take_action);
      end
      if (take_action != 4'b0000) begin
         ta_pulses++;
         last_ta = take_action;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic ir_update(input logic [1:0] v);
      ir_in = v; vs_uir = 1'b1;
      wait_cyc(4);
      vs_uir = 1'b0;
      wait_cyc(3);
   endtask

   task automatic dr_event(input logic [37:0] d);
      sr = d; vs_e1dr = 1'b1;
      wait_cyc(4);
      vs_e1dr = 1'b0;
      wait_cyc(3);
   endtask

   task automatic both_event(input logic [1:0] v, input logic [37:0] d);
      ir_in = v; sr = d; vs_uir = 1'b1; vs_e1dr = 1'b1;
      wait_cyc(4);
      vs_uir = 1'b0; vs_e1dr = 1'b0;
      wait_cyc(3);
   endtask

   task automatic drain();
      cmd_ready = 1'b1;
      wait_cyc(DEPTH + 2);
      cmd_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] rnd;
      logic [1:0]  r2;
      int          op;

      wait_cyc(3);
      reset = 1'b0;
      chk("rst_valid", 64'(cmd_valid), 64'd0);
      chk("rst_take", 64'(take_action), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);
      wait_cyc(4);

      // Single command popped immediately
      cmd_ready = 1'b1;
      ta_pulses = 0;
      log_d.delete(); log_ir.delete();
      ir_update(BREAK);
      dr_event(38'h15);
      chk("single_pulses", 64'(ta_pulses), 64'd1);
      chk("single_take", 64'(last_ta), 64'b0100);
      chk("single_ir", 64'(log_ir.size() > 0 ? log_ir[0] : 2'd0), 64'd2);
      chk("single_jdo", 64'(log_d.size() > 0 ? log_d[0] : 38'd0), 64'h15);
      cmd_ready = 1'b0;

      // Overflow: six events into a four-deep queue
      log_d.delete(); log_ir.delete();
      for (int i = 1; i <= 6; i++) dr_event(38'(i));
      chk("ovf_set", 64'(overflow), 64'd1);
      chk("ovf_drops", 64'(drop_count), 64'd2);
      drain();
      chk("ovf_npop", 64'(log_d.size()), 64'd4);
      for (int i = 0; i < 4; i++)
         if (i < log_d.size()) chk("ovf_order", 64'(log_d[i]), 64'(i + 1));
      ovf_clr = 1'b1;
      wait_cyc(1);
      ovf_clr = 1'b0;
      wait_cyc(1);
      chk("ovf_clr_flag", 64'(overflow), 64'd0);
      chk("ovf_clr_cnt", 64'(drop_count), 64'd0);

      // Full queue with a pop on the very cycle of a new push
      log_d.delete(); log_ir.delete();
      for (int i = 1; i <= 4; i++) dr_event(38'(i));
      sr = 38'd5; vs_e1dr = 1'b1;
      wait_cyc(4);
      cmd_ready = 1'b1;
      wait_cyc(1);
      cmd_ready = 1'b0;
      vs_e1dr = 1'b0;
      wait_cyc(3);
      chk("full_pp_ovf", 64'(overflow), 64'd0);
      chk("full_pp_drop", 64'(drop_count), 64'd0);
      drain();
      chk("full_pp_npop", 64'(log_d.size()), 64'd5);
      for (int i = 1; i < 5; i++)
         if (i < log_d.size()) chk("full_pp_order", 64'(log_d[i]), 64'(i + 1));

      // Coincident IR and DR updates
      ir_update(TRACE);
      log_d.delete(); log_ir.delete();
      both_event(TRACECTRL, 38'hA);
      dr_event(38'hB);
      drain();
      chk("coinc_npop", 64'(log_ir.size()), 64'd2);
      chk("coinc_ir0", 64'(log_ir.size() > 0 ? log_ir[0] : 2'd0), 64'(TRACE));
      chk("coinc_ir1", 64'(log_ir.size() > 1 ? log_ir[1] : 2'd0), 64'(TRACECTRL));

      // Level held high across reset release
      vs_e1dr = 1'b1; sr = 38'h3C;
      reset = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      wait_cyc(8);
      chk("held_nopush", 64'(cmd_valid), 64'd0);
      vs_e1dr = 1'b0;
      wait_cyc(3);
      dr_event(38'hC);
      chk("held_later_push", 64'(cmd_valid), 64'd1);
      log_d.delete(); log_ir.delete();
      drain();
      chk("held_npop", 64'(log_d.size()), 64'd1);

      // Reset with queued entries
      for (int i = 0; i < 3; i++) dr_event(38'(8'h40 + i));
      chk("flush_pre", 64'(cmd_valid), 64'd1);
      reset = 1'b1;
      wait_cyc(1);
      chk("flush_valid", 64'(cmd_valid), 64'd0);
      reset = 1'b0;
      wait_cyc(4);
      log_d.delete(); log_ir.delete();
      dr_event(38'h77);
      drain();
      chk("flush_first", 64'(log_d.size() > 0 ? log_d[0] : 38'd0), 64'h77);

      // Randomised traffic
      for (int n = 0; n < 150; n++) begin
         op = int'($urandom_range(0, 4));
         cmd_ready = 1'($urandom_range(0, 1));
         ovf_clr = ($urandom_range(0, 9) == 0);
         rnd = {$urandom(), $urandom()};
         r2 = 2'($urandom_range(0, 3));
         case (op)
            0:       ir_update(r2);
            1, 2:    dr_event(rnd[37:0]);
            3:       both_event(r2, rnd[37:0]);
            default: wait_cyc(int'($urandom_range(1, 6)));
         endcase
         ovf_clr = 1'b0;
      end
      drain();
      chk("final_empty", 64'(cmd_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
